// File: rtl/int_div_pkg.sv
// Shared types and message layout constants for the iterative restoring divider.
// Optional early-exit build is selected with INT_DIV_ITER_EARLY_EXIT_EN.
package int_div_pkg;

    localparam int DEFAULT_NBITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Field indices into the two-field stream messages (field 1 is the upper half)
    localparam int IN_DIVISOR_FIELD    = 0;
    localparam int IN_DIVIDEND_FIELD   = 1;
    localparam int OUT_REMAINDER_FIELD = 0;
    localparam int OUT_QUOTIENT_FIELD  = 1;

    function automatic int field_lsb(input int field, input int nbits);
        return field * nbits;
    endfunction

endpackage

// File: rtl/int_div_iter_ctrl.sv
// Divider control FSM (IDLE/CALC/DONE) driving datapath enables and the stream handshake.
// INT_DIV_ITER_EARLY_EXIT_EN adds the zero-dividend shortcut straight to DONE.
module int_div_iter_ctrl
    import int_div_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic istream_val,
    input  logic ostream_rdy,
    input  logic count_done,
    input  logic diff_sign,
`ifdef INT_DIV_ITER_EARLY_EXIT_EN
    input  logic dividend_zero,
    input  logic divisor_zero,
`endif
    output logic istream_rdy,
    output logic ostream_val,
    output logic load,
    output logic shift,
    output logic count_dec,
    output logic sub_sel
);

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        count_dec   = 1'b0;
        sub_sel     = 1'b0;
        case (state)
            IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    load       = 1'b1;
                    state_next = CALC;
`ifdef INT_DIV_ITER_EARLY_EXIT_EN
                    if (dividend_zero && !divisor_zero) state_next = DONE;
`endif
                end
            end
            CALC: begin
                shift     = 1'b1;
                count_dec = 1'b1;
                sub_sel   = !diff_sign;
                if (count_done) state_next = DONE;
            end
            DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/int_div_iter_dpath.sv
// Divider datapath: remainder, quotient/dividend shift register, divisor and iteration counter.
// INT_DIV_ITER_EARLY_EXIT_EN adds leading-zero preload of the dividend.
module int_div_iter_dpath
    import int_div_pkg::*;
#(
    parameter int NBITS = DEFAULT_NBITS,
    parameter int CW    = $clog2(NBITS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] dividend,
    input  logic [NBITS-1:0] divisor,
    input  logic             load,
    input  logic             shift,
    input  logic             count_dec,
    input  logic             sub_sel,
    output logic             count_done,
    output logic             diff_sign,
`ifdef INT_DIV_ITER_EARLY_EXIT_EN
    output logic             dividend_zero,
    output logic             divisor_zero,
`endif
    output logic [NBITS-1:0] quotient,
    output logic [NBITS-1:0] remainder
);

    logic [NBITS:0]   r;
    logic [NBITS:0]   r_shift;
    logic [NBITS:0]   diff;
    logic [NBITS-1:0] q;
    logic [NBITS-1:0] d;
    logic [NBITS-1:0] q_init;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_init;
    logic             unused_r_msb;

    assign r_shift      = {r[NBITS-1:0], q[NBITS-1]};
    assign diff         = r_shift - {1'b0, d};
    assign diff_sign    = diff[NBITS];
    assign count_done   = (cnt == CW'(1));
    assign quotient     = q;
    assign remainder    = r[NBITS-1:0];
    // The remainder never reaches 2^NBITS after a step, so its top bit is not observed
    assign unused_r_msb = r[NBITS];

`ifdef INT_DIV_ITER_EARLY_EXIT_EN
    logic [CW-1:0] lz;

    int_div_lzc #(.NBITS(NBITS), .CW(CW)) u_lzc (
        .value (dividend),
        .count (lz)
    );

    assign dividend_zero = (dividend == '0);
    assign divisor_zero  = (divisor == '0);

    // Leading zeros cannot change the remainder, so skip them unless dividing by zero
    always_comb begin
        q_init   = dividend;
        cnt_init = CW'(NBITS);
        if (!divisor_zero) begin
            q_init   = dividend << lz;
            cnt_init = CW'(NBITS) - lz;
        end
    end
`else
    assign q_init   = dividend;
    assign cnt_init = CW'(NBITS);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r   <= '0;
            q   <= '0;
            d   <= '0;
            cnt <= '0;
        end else if (load) begin
            r   <= '0;
            q   <= q_init;
            d   <= divisor;
            cnt <= cnt_init;
        end else begin
            if (shift) begin
                r <= sub_sel ? diff : r_shift;
                q <= {q[NBITS-2:0], sub_sel};
            end
            if (count_dec) cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/int_div_lzc.sv
// Parameterised leading-zero counter; only built for INT_DIV_ITER_EARLY_EXIT_EN.
`ifdef INT_DIV_ITER_EARLY_EXIT_EN
module int_div_lzc #(
    parameter int NBITS = 32,
    parameter int CW    = $clog2(NBITS) + 1
) (
    input  logic [NBITS-1:0] value,
    output logic [CW-1:0]    count
);

    // Ascending scan so the most significant set bit is the last to write
    always_comb begin
        count = CW'(NBITS);
        for (int i = 0; i < NBITS; i++) begin
            if (value[i]) count = CW'(NBITS - 1 - i);
        end
    end

endmodule
`endif

// File: rtl/int_div_iter.sv
// Iterative restoring unsigned divider with val/rdy streams, one quotient bit per cycle.
// Define INT_DIV_ITER_EARLY_EXIT_EN to skip leading-zero iterations of the dividend.
module int_div_iter
    import int_div_pkg::*;
#(
    parameter int NBITS = DEFAULT_NBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [2*NBITS-1:0] istream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [2*NBITS-1:0] ostream_msg
);

    localparam int DIVIDEND_LSB  = field_lsb(IN_DIVIDEND_FIELD, NBITS);
    localparam int DIVISOR_LSB   = field_lsb(IN_DIVISOR_FIELD, NBITS);
    localparam int QUOTIENT_LSB  = field_lsb(OUT_QUOTIENT_FIELD, NBITS);
    localparam int REMAINDER_LSB = field_lsb(OUT_REMAINDER_FIELD, NBITS);

    logic             load;
    logic             shift;
    logic             count_dec;
    logic             sub_sel;
    logic             count_done;
    logic             diff_sign;
    logic [NBITS-1:0] quotient;
    logic [NBITS-1:0] remainder;
`ifdef INT_DIV_ITER_EARLY_EXIT_EN
    logic             dividend_zero;
    logic             divisor_zero;
`endif

    int_div_iter_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .istream_val   (istream_val),
        .ostream_rdy   (ostream_rdy),
        .count_done    (count_done),
        .diff_sign     (diff_sign),
`ifdef INT_DIV_ITER_EARLY_EXIT_EN
        .dividend_zero (dividend_zero),
        .divisor_zero  (divisor_zero),
`endif
        .istream_rdy   (istream_rdy),
        .ostream_val   (ostream_val),
        .load          (load),
        .shift         (shift),
        .count_dec     (count_dec),
        .sub_sel       (sub_sel)
    );

    int_div_iter_dpath #(.NBITS(NBITS)) u_dpath (
        .clk           (clk),
        .reset         (reset),
        .dividend      (istream_msg[DIVIDEND_LSB +: NBITS]),
        .divisor       (istream_msg[DIVISOR_LSB +: NBITS]),
        .load          (load),
        .shift         (shift),
        .count_dec     (count_dec),
        .sub_sel       (sub_sel),
        .count_done    (count_done),
        .diff_sign     (diff_sign),
`ifdef INT_DIV_ITER_EARLY_EXIT_EN
        .dividend_zero (dividend_zero),
        .divisor_zero  (divisor_zero),
`endif
        .quotient      (quotient),
        .remainder     (remainder)
    );

    // Response is held at zero whenever no valid result is being offered
    always_comb begin
        ostream_msg = '0;
        if (ostream_val) begin
            ostream_msg[QUOTIENT_LSB +: NBITS]  = quotient;
            ostream_msg[REMAINDER_LSB +: NBITS] = remainder;
        end
    end

endmodule

// File: tb/tb_int_div_iter.sv
// Directed bench for int_div_iter: vector table plus backpressure and mid-operation reset sequences.
// Expected latencies follow INT_DIV_ITER_EARLY_EXIT_EN when it is defined for the build.
module tb_int_div_iter;

    localparam int NBITS   = 32;
    localparam int TIMEOUT = 100;
`ifdef INT_DIV_ITER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [NBITS-1:0]   dividend;
        logic [NBITS-1:0]   divisor;
        logic [2*NBITS-1:0] exp_msg;
        int                 lat_off;
        int                 lat_on;
    } vec_t;

    logic               clk;
    logic               reset;
    logic               istream_val;
    logic               istream_rdy;
    logic [2*NBITS-1:0] istream_msg;
    logic               ostream_val;
    logic               ostream_rdy;
    logic [2*NBITS-1:0] ostream_msg;

    int checks;
    int passes;
    vec_t vecs [13];

    int_div_iter #(.NBITS(NBITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [2*NBITS-1:0] actual,
                                input logic [2*NBITS-1:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
    endtask

    // Latency counts cycles from the accept cycle to the first cycle with ostream_val high
    task automatic apply_stimulus(input logic [NBITS-1:0] dividend, input logic [NBITS-1:0] divisor,
                                  output logic [2*NBITS-1:0] msg, output int lat);
        int guard;
        @(negedge clk);
        istream_msg = {dividend, divisor};
        istream_val = 1'b1;
        guard = 0;
        while (!istream_rdy && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        istream_msg = '0;
        lat = 1;
        while (!ostream_val && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        msg = ostream_msg;
    endtask

    initial begin
        logic [2*NBITS-1:0] msg;
        logic [2*NBITS-1:0] bp_exp;
        int lat;
        int guard;

        checks = 0;
        passes = 0;
        vecs[0]  = '{32'd100,        32'd7,          64'h0000000E_00000002, 33, 8};
        vecs[1]  = '{32'hFFFFFFFF,   32'd1,          64'hFFFFFFFF_00000000, 33, 33};
        vecs[2]  = '{32'd3,          32'd10,         64'h00000000_00000003, 33, 3};
        vecs[3]  = '{32'd5,          32'd0,          64'hFFFFFFFF_00000005, 33, 33};
        vecs[4]  = '{32'd0,          32'd0,          64'hFFFFFFFF_00000000, 33, 33};
        vecs[5]  = '{32'd42,         32'd5,          64'h00000008_00000002, 33, 7};
        vecs[6]  = '{32'd1000,       32'd33,         64'h0000001E_0000000A, 33, 11};
        vecs[7]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000001_00000000, 33, 33};
        vecs[8]  = '{32'h80000000,   32'h00010000,   64'h00008000_00000000, 33, 33};
        vecs[9]  = '{32'h000000FF,   32'd3,          64'h00000055_00000000, 33, 9};
        vecs[10] = '{32'd0,          32'd9,          64'h00000000_00000000, 33, 1};
        vecs[11] = '{32'h000000FF,   32'd0,          64'hFFFFFFFF_000000FF, 33, 33};
        vecs[12] = '{32'd7,          32'd7,          64'h00000001_00000000, 33, 4};

        reset       = 1'b1;
        istream_val = 1'b0;
        istream_msg = '0;
        ostream_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_output("reset_istream_rdy", 64'(istream_rdy), 64'd1);
        check_output("reset_ostream_val", 64'(ostream_val), 64'd0);
        check_output("reset_ostream_msg", ostream_msg, 64'd0);

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].dividend, vecs[i].divisor, msg, lat);
            check_output($sformatf("vec%0d_msg", i), msg, vecs[i].exp_msg);
            check_output($sformatf("vec%0d_latency", i), 64'(lat),
                         64'(EARLY ? vecs[i].lat_on : vecs[i].lat_off));
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d_rdy_after", i), 64'(istream_rdy), 64'd1);
            check_output($sformatf("vec%0d_val_after", i), 64'(ostream_val), 64'd0);
        end

        // Backpressure: a competing request stays pending while the result is held
        bp_exp = 64'h0000000E_00000002;
        ostream_rdy = 1'b0;
        @(negedge clk);
        istream_val = 1'b1;
        istream_msg = {32'd100, 32'd7};
        @(posedge clk);
        #1;
        istream_msg = {32'd3, 32'd10};
        check_output("bp_calc_rdy", 64'(istream_rdy), 64'd0);
        guard = 0;
        while (!ostream_val && guard < TIMEOUT) begin
            @(posedge clk);
            #1;
            guard++;
        end
        for (int c = 0; c < 10; c++) begin
            check_output($sformatf("bp_val_c%0d", c), 64'(ostream_val), 64'd1);
            check_output($sformatf("bp_msg_c%0d", c), ostream_msg, bp_exp);
            check_output($sformatf("bp_rdy_c%0d", c), 64'(istream_rdy), 64'd0);
            @(posedge clk);
            #1;
        end
        istream_val = 1'b0;
        istream_msg = '0;
        ostream_rdy = 1'b1;
        check_output("bp_msg_release", ostream_msg, bp_exp);
        @(posedge clk);
        #1;
        check_output("bp_rdy_after", 64'(istream_rdy), 64'd1);
        check_output("bp_val_after", 64'(ostream_val), 64'd0);

        // Reset during the fifth CALC cycle drops the transaction
        @(negedge clk);
        istream_val = 1'b1;
        istream_msg = {32'd100, 32'd7};
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        istream_msg = '0;
        repeat (4) @(posedge clk);
        #1;
        check_output("mid_calc_rdy", 64'(istream_rdy), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_output("mid_reset_val", 64'(ostream_val), 64'd0);
        check_output("mid_reset_rdy", 64'(istream_rdy), 64'd1);
        check_output("mid_reset_msg", ostream_msg, 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("mid_idle_val_c%0d", c), 64'(ostream_val), 64'd0);
        end
        apply_stimulus(32'd42, 32'd5, msg, lat);
        check_output("post_reset_msg", msg, 64'h00000008_00000002);
        check_output("post_reset_latency", 64'(lat), 64'(EARLY ? 7 : 33));
        @(posedge clk);
        #1;
        check_output("post_reset_rdy", 64'(istream_rdy), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
